// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit multicycle CPU control path.
// Opcode map, ALUOp classes (also decoded by alu_control), datapath mux
// encodings and the main control FSM state type.
package cpu16_pkg;

  localparam logic [3:0] OP_R0  = 4'b0000;
  localparam logic [3:0] OP_R1  = 4'b0001;
  localparam logic [3:0] OP_R2  = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b0110;
  localparam logic [3:0] OP_BNE = 4'b0111;
  localparam logic [3:0] OP_J   = 4'b1000;
  localparam logic [3:0] OP_I0  = 4'b1001;
  localparam logic [3:0] OP_I1  = 4'b1010;
  localparam logic [3:0] OP_I2  = 4'b1011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_WB_R,
    ST_EXEC_I,
    ST_WB_I,
    ST_ADDR,
    ST_MEM_RD,
    ST_WB_MEM,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JUMP,
    ST_TRAP
  } state_t;

  // States that hold a memory request open until MemReady
  function automatic logic is_mem_state(state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait watchdog: a down-counter that runs while an access is stalled
// and flags expiry on the WAIT_MAX-th consecutive stalled cycle.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic active,
  output logic expire
);

  localparam int TW = $clog2(WAIT_MAX + 1);
  localparam logic [TW-1:0] LOAD = TW'(WAIT_MAX - 1);

  logic [TW-1:0] count;

  assign expire = active && (count == '0);

  // Reload whenever the stall is broken or has just expired, else count down
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      count <= LOAD;
    end else if (!active || expire) begin
      count <= LOAD;
    end else begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the 16-bit multicycle CPU.
// Optional feature macro: ILLEGAL_TRAP_EN -- illegal opcodes park the FSM in
// TRAP and raise IllegalOp; without it they retire as NOPs.
//
// state     | meaning
// IDLE      | first cycle out of reset
// FETCH     | instruction read at PC, PC+1 written on MemReady
// DECODE    | branch target precomputed into ALUOut, opcode dispatch
// EXEC_R    | R-type ALU op (funct)
// WB_R      | write rd
// EXEC_I    | I-type ALU op (opcode)
// WB_I      | write rt
// ADDR      | effective address rs + imm
// MEM_RD    | data read at ALUOut
// WB_MEM    | write MDR to rt
// MEM_WR    | data write at ALUOut
// BRANCH    | compare rs/rt, conditional PC load from ALUOut
// JUMP      | PC load with jump target
// TRAP      | illegal opcode, held until reset
module multicycle_control
  import cpu16_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [3:0]       OPCode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             BusErr,
`ifdef ILLEGAL_TRAP_EN
  output logic             IllegalOp,
`endif
  output logic [CNT_W-1:0] RetireCnt
);

  state_t state, state_next;
  logic   retire;
  logic   wait_active;
  logic   wait_expire;

  // Zero only feeds the datapath PC-load gate; control never looks at it
  logic unused_zero;
  assign unused_zero = Zero;

  assign wait_active = is_mem_state(state) && !MemReady;

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .clk_sys (Clock),
    .rst_b   (Reset_n),
    .active  (wait_active),
    .expire  (wait_expire)
  );

  // State, sticky bus error and retired-instruction counter
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      BusErr    <= 1'b0;
      RetireCnt <= '0;
    end else begin
      state <= state_next;
      if (wait_expire) BusErr <= 1'b1;
      if (retire) RetireCnt <= RetireCnt + 1'b1;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_next  = state;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
`ifdef ILLEGAL_TRAP_EN
    IllegalOp   = 1'b0;
`endif
    case (state)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_ONE;
        ALUOp   = ALUOP_ADD;
        if (MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = ST_DECODE;
        end
        // on expiry the fetch is simply restarted
      end
      ST_DECODE: begin
        ALUSrcB = SRCB_BROFF;
        ALUOp   = ALUOP_ADD;
        case (OPCode)
          OP_R0, OP_R1, OP_R2: state_next = ST_EXEC_R;
          OP_I0, OP_I1, OP_I2: state_next = ST_EXEC_I;
          OP_LW, OP_SW:        state_next = ST_ADDR;
          OP_BEQ, OP_BNE:      state_next = ST_BRANCH;
          OP_J:                state_next = ST_JUMP;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_next = ST_TRAP;
`else
            state_next = ST_FETCH;
            retire     = 1'b1;
`endif
          end
        endcase
      end
      ST_EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_RT;
        ALUOp      = ALUOP_RTYPE;
        state_next = ST_WB_R;
      end
      ST_WB_R: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        state_next = ST_FETCH;
        retire     = 1'b1;
      end
      ST_EXEC_I: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_ITYPE;
        state_next = ST_WB_I;
      end
      ST_WB_I: begin
        RegWrite   = 1'b1;
        state_next = ST_FETCH;
        retire     = 1'b1;
      end
      ST_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_ADD;
        state_next = (OPCode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_next = ST_WB_MEM;
        else if (wait_expire) state_next = ST_FETCH;
      end
      ST_WB_MEM: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        state_next = ST_FETCH;
        retire     = 1'b1;
      end
      ST_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          state_next = ST_FETCH;
          retire     = 1'b1;
        end else if (wait_expire) begin
          state_next = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_RT;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        BranchNe    = (OPCode == OP_BNE);
        state_next  = ST_FETCH;
        retire      = 1'b1;
      end
      ST_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        state_next = ST_FETCH;
        retire     = 1'b1;
      end
      ST_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        IllegalOp = 1'b1;
`endif
        state_next = ST_TRAP;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction-level bench for multicycle_control with a
// per-cycle expectation scoreboard. Honors ILLEGAL_TRAP_EN when defined.
module tb_multicycle_control;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 16;

  logic             Clock = 1'b0;
  logic             Reset_n;
  logic [3:0]       OPCode;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite;
  logic             IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]       ALUSrcB, ALUOp, PCSource;
  logic             BusErr;
  logic [CNT_W-1:0] RetireCnt;
  logic             ill_obs;

`ifdef ILLEGAL_TRAP_EN
  logic IllegalOp;
  assign ill_obs = IllegalOp;
`else
  assign ill_obs = 1'b0;
`endif

  always #5 Clock = ~Clock;

  multicycle_control #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .OPCode      (OPCode),
    .Zero        (Zero),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .BranchNe    (BranchNe),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .BusErr      (BusErr),
`ifdef ILLEGAL_TRAP_EN
    .IllegalOp   (IllegalOp),
`endif
    .RetireCnt   (RetireCnt)
  );

  typedef struct packed {
    logic pcw, pcwc, bne, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
    logic [1:0] srcb, aop, psrc;
  } ctl_t;

  typedef struct packed {
    ctl_t             c;
    logic             berr;
    logic [CNT_W-1:0] cnt;
    logic             ill;
  } exp_t;

  typedef enum {P_IDLE, P_FETCH_W, P_FETCH_D, P_DECODE, P_EXEC_R, P_WB_R,
                P_EXEC_I, P_WB_I, P_ADDR, P_MEM_RD, P_WB_MEM, P_MEM_WR,
                P_BRANCH, P_JUMP, P_TRAP} phase_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  int   m_cnt    = 0;
  bit   m_berr   = 1'b0;
  logic [3:0] legal_ops [11] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6,
                                 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};

  // Control word each instruction phase is expected to present
  function automatic ctl_t word(phase_t p, logic [3:0] op);
    ctl_t c = '0;
    case (p)
      P_FETCH_W: begin c.mrd = 1; c.srcb = 2'b01; end
      P_FETCH_D: begin c.mrd = 1; c.srcb = 2'b01; c.irw = 1; c.pcw = 1; end
      P_DECODE:  c.srcb = 2'b11;
      P_EXEC_R:  begin c.srca = 1; c.aop = 2'b10; end
      P_WB_R:    begin c.rdst = 1; c.rw = 1; end
      P_EXEC_I:  begin c.srca = 1; c.srcb = 2'b10; c.aop = 2'b11; end
      P_WB_I:    c.rw = 1;
      P_ADDR:    begin c.srca = 1; c.srcb = 2'b10; end
      P_MEM_RD:  begin c.mrd = 1; c.iord = 1; end
      P_WB_MEM:  begin c.m2r = 1; c.rw = 1; end
      P_MEM_WR:  begin c.mwr = 1; c.iord = 1; end
      P_BRANCH:  begin c.srca = 1; c.aop = 2'b01; c.pcwc = 1; c.psrc = 2'b01;
                       c.bne = (op == 4'd7); end
      P_JUMP:    begin c.pcw = 1; c.psrc = 2'b10; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t get_obs();
    ctl_t c;
    c.pcw = PCWrite;  c.pcwc = PCWriteCond; c.bne = BranchNe; c.iord = IorD;
    c.mrd = MemRead;  c.mwr = MemWrite;     c.irw = IRWrite;  c.rdst = RegDst;
    c.m2r = MemtoReg; c.rw = RegWrite;      c.srca = ALUSrcA; c.srcb = ALUSrcB;
    c.aop = ALUOp;    c.psrc = PCSource;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one expectation per cycle, sampled mid-cycle
  always @(negedge Clock) begin : mon
    exp_t e;
    exp_t o;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      o.c = get_obs(); o.berr = BusErr; o.cnt = RetireCnt; o.ill = ill_obs;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL cycle op=%0d ctl=%h/%h berr=%b/%b cnt=%0d/%0d ill=%b/%b (actual/required) t=%0t",
                 OPCode, o.c, e.c, o.berr, e.berr, o.cnt, e.cnt, o.ill, e.ill, $time);
      end
    end
  end

  // Drive one cycle of stimulus and record what the DUT must show in it
  task automatic step(input logic [3:0] op, input logic mr, input ctl_t c, input logic ill);
    exp_t e;
    @(posedge Clock);
    #1;
    OPCode   = op;
    MemReady = mr;
    Zero     = 1'($urandom_range(0, 1));
    e.c = c; e.berr = m_berr; e.cnt = m_cnt[CNT_W-1:0]; e.ill = ill;
    sb.push_back(e);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // A memory access stalled for 'waits' cycles; WAIT_MAX or more aborts it
  task automatic access(input logic [3:0] op, input int waits, input phase_t pw,
                        input phase_t pd, output bit ok);
    int n;
    n = (waits >= WAIT_MAX) ? WAIT_MAX : waits;
    for (int i = 0; i < n; i++) step(op, 1'b0, word(pw, op), 1'b0);
    if (waits >= WAIT_MAX) begin
      m_berr = 1'b1;
      ok = 1'b0;
    end else begin
      step(op, 1'b1, word(pd, op), 1'b0);
      ok = 1'b1;
    end
  endtask

  task automatic instr(input logic [3:0] op, input int fw, input int mw);
    bit ok;
    access(op, fw, P_FETCH_W, P_FETCH_D, ok);
    if (!ok) return;
    step(op, rnd_bit(), word(P_DECODE, op), 1'b0);
    if (op <= 4'd2) begin
      step(op, rnd_bit(), word(P_EXEC_R, op), 1'b0);
      step(op, rnd_bit(), word(P_WB_R, op), 1'b0);
    end else if (op >= 4'd9 && op <= 4'd11) begin
      step(op, rnd_bit(), word(P_EXEC_I, op), 1'b0);
      step(op, rnd_bit(), word(P_WB_I, op), 1'b0);
    end else if (op == 4'd4) begin
      step(op, rnd_bit(), word(P_ADDR, op), 1'b0);
      access(op, mw, P_MEM_RD, P_MEM_RD, ok);
      if (!ok) return;
      step(op, rnd_bit(), word(P_WB_MEM, op), 1'b0);
    end else if (op == 4'd5) begin
      step(op, rnd_bit(), word(P_ADDR, op), 1'b0);
      access(op, mw, P_MEM_WR, P_MEM_WR, ok);
      if (!ok) return;
    end else if (op == 4'd6 || op == 4'd7) begin
      step(op, rnd_bit(), word(P_BRANCH, op), 1'b0);
    end else if (op == 4'd8) begin
      step(op, rnd_bit(), word(P_JUMP, op), 1'b0);
    end else begin
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 6; i++) step(op, rnd_bit(), '0, 1'b1);
      return;
`endif
    end
    m_cnt++;
  endtask

  function automatic int rnd_waits();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return WAIT_MAX + $urandom_range(0, 2);
    if (r < 12) return 0;
    return $urandom_range(1, 4);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    Reset_n = 1'b0; MemReady = 1'b0; OPCode = 4'd0; Zero = 1'b0;
    repeat (2) @(negedge Clock);
    chk("reset_ctl", 32'(get_obs()), 32'd0);
    chk("reset_buserr", 32'(BusErr), 32'd0);
    chk("reset_retire", 32'(RetireCnt), 32'd0);
    Reset_n = 1'b1;
    #1;
    chk("idle_ctl", 32'(get_obs()), 32'd0);

    for (int k = 0; k < 150; k++) begin
`ifdef ILLEGAL_TRAP_EN
      op = legal_ops[$urandom_range(0, 10)];
`else
      op = 4'($urandom_range(0, 15));
`endif
      instr(op, rnd_waits(), rnd_waits());
    end

    instr(4'd1, 0, 0);          // ADD
    instr(4'd4, 0, 3);          // LW, 3 stalled cycles
    instr(4'd7, 0, 0);          // BNE
    instr(4'd5, 0, 14);         // SW completing on the last allowed cycle
    instr(4'd1, WAIT_MAX, 0);   // fetch stuck low -> bus error
    instr(4'd9, WAIT_MAX - 1, 0);
    instr(4'd4, 0, WAIT_MAX);   // data read abandoned
    instr(4'd15, 0, 0);         // illegal opcode

    @(negedge Clock);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of a stalled store
    #2;
    Reset_n = 1'b0;
    #1;
    chk("reset2_buserr", 32'(BusErr), 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1; MemReady = 1'b1; OPCode = 4'd5;
    @(posedge Clock); #1;
    chk("rst_fetch_mrd", 32'(MemRead), 32'd1);
    @(posedge Clock); #1;
    chk("rst_decode_srcb", 32'(ALUSrcB), 32'd3);
    MemReady = 1'b0;
    @(posedge Clock); #1;
    chk("rst_addr_srca", 32'(ALUSrcA), 32'd1);
    @(posedge Clock); #1;
    chk("memwr_active", 32'(MemWrite), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("memwr_dropped", 32'(MemWrite), 32'd0);
    chk("memwr_iord_dropped", 32'(IorD), 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    MemReady = 1'b1;
    #1;
    chk("idle_after_reset", 32'(get_obs()), 32'd0);
    @(posedge Clock); #1;
    chk("fetch_after_reset", 32'(MemRead), 32'd1);
    chk("retire_after_reset", 32'(RetireCnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
